// File: rtl/regfile_pkg.sv
// Shared types and constants for the general register file write side.
package regfile_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned NREG  = 16;

  typedef logic [3:0]       reg_addr_t;
  typedef logic [REG_W-1:0] word_t;

  localparam reg_addr_t PC_IDX  = 4'hF;
  localparam word_t     PC_STEP = 32'd4;

endpackage

// File: rtl/binary_decoder_4x16.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when en is low.
module binary_decoder_4x16
  import regfile_pkg::*;
(
  input  logic        en,
  input  logic [3:0]  addr,
  output logic [15:0] load
);

  always_comb begin
    load = '0;
    if (en) load[addr] = 1'b1;
  end

endmodule

// File: rtl/mux_16x1_32b.sv
// 16:1 selector of 32-bit words, used for the register file read ports.
module mux_16x1_32b (
  input  logic [15:0][31:0] din,
  input  logic [3:0]        sel,
  output logic [31:0]       dout
);

  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/regfile_16x32_wr.sv
// Sixteen-entry register file: decoded write port, two bypassed read ports,
// and R15 acting as the program counter with its own increment path.
module regfile_16x32_wr
  import regfile_pkg::*;
#(
  parameter int unsigned     WIDTH   = REG_W,
  parameter int unsigned     NREG    = 16,
  parameter logic [WIDTH-1:0] PC_STEP = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_inc,
  input  logic [3:0]       rd_sel_a,
  input  logic [3:0]       rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] pc_out
);

  logic [NREG-1:0][WIDTH-1:0] regs;
  logic [NREG-1:0]            load;
  logic [WIDTH-1:0]           mux_a;
  logic [WIDTH-1:0]           mux_b;
  logic                       byp_a;
  logic                       byp_b;

  binary_decoder_4x16 u_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .load (load)
  );

  // Explicit load of R15 takes precedence over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (load[i])
          regs[i] <= wr_data;
        else if (i == 32'(PC_IDX) && pc_inc)
          regs[i] <= regs[i] + PC_STEP;
      end
    end
  end

  mux_16x1_32b u_mux_a (
    .din  (regs),
    .sel  (rd_sel_a),
    .dout (mux_a)
  );

  mux_16x1_32b u_mux_b (
    .din  (regs),
    .sel  (rd_sel_b),
    .dout (mux_b)
  );

  // Bypass follows only the write port; a pending pc_inc is not forwarded.
  always_comb begin
    byp_a     = wr_en && (wr_addr == rd_sel_a);
    byp_b     = wr_en && (wr_addr == rd_sel_b);
    rd_data_a = byp_a ? wr_data : mux_a;
    rd_data_b = byp_b ? wr_data : mux_b;
  end

  assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_regfile_16x32_wr.sv
// Randomized and directed checks of regfile_16x32_wr against an array model.
module tb_regfile_16x32_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_inc;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] pc_out;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] model [16];

  regfile_16x32_wr #(.WIDTH(32), .NREG(16), .PC_STEP(32'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_inc    (pc_inc),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic we, input logic [3:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
    return (we && a == s) ? d : model[s];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
  endtask

  // One cycle: drive at negedge, check reads before the edge, PC after it.
  task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic inc, input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    wr_en = we; wr_addr = a; wr_data = d; pc_inc = inc;
    rd_sel_a = sa; rd_sel_b = sb;
    #1;
    check("rd_a", rd_data_a, exp_rd(we, a, d, sa));
    check("rd_b", rd_data_b, exp_rd(we, a, d, sb));
    check("pc_pre", pc_out, model[15]);
    @(posedge clk);
    if (we) model[a] = d;
    if (inc && !(we && a == 4'd15)) model[15] = model[15] + 32'd4;
    #1;
    check("pc_post", pc_out, model[15]);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, a, 4'd15);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc_inc = 1'b0;
    rd_sel_a = '0; rd_sel_b = '0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", pc_out, 32'd0);
    check("rst_rd_a", rd_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle
    wr(4'd3, 32'h00000003);
    @(negedge clk);
    wr_en = 1'b0; rd_sel_a = 4'd3; rd_sel_b = 4'd15;
    #1;
    check("r3_loaded", rd_data_a, 32'h00000003);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_r3", rd_data_a, 32'd0);
    check("async_rst_pc", pc_out, 32'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read sweep
    for (int i = 0; i < 16; i++) wr(4'(i), 32'(i) << 4);
    for (int s = 0; s < 16; s++) begin
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'(s), 4'(15 - s));
      check("sweep_a", rd_data_a, 32'(s) << 4);
      check("sweep_b", rd_data_b, 32'(15 - s) << 4);
    end

    // Write-through bypass on both ports
    wr(4'd7, 32'h00000070);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00010000; pc_inc = 1'b0;
    rd_sel_a = 4'd7; rd_sel_b = 4'd7;
    #1;
    check("byp_a", rd_data_a, 32'h00010000);
    check("byp_b", rd_data_b, 32'h00010000);
    @(posedge clk);
    model[7] = 32'h00010000;
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd7, 4'd7);
    check("r7_after", rd_data_a, 32'h00010000);

    // PC priority, no bypass of pending increment
    wr(4'd15, 32'h00000100);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd15);
    check("pc_inc", pc_out, 32'h00000104);
    step(1'b1, 4'd15, 32'h000000A0, 1'b1, 4'd15, 4'd0);
    check("pc_load_wins", pc_out, 32'h000000A0);

    // PC wrap
    wr(4'd15, 32'hFFFFFFFC);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd15);
    check("pc_wrap", pc_out, 32'h00000000);

    // Writes disabled while address/data toggle
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'($urandom), $urandom, 1'b0, 4'($urandom), 4'($urandom));
    for (int s = 0; s < 16; s++)
      step(1'b0, 4'(s), ~model[s], 1'b0, 4'(s), 4'(s));

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 1) == 1), 4'($urandom), $urandom,
           ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
